waverforms_mul_arbiter: RTL
===========================

# waverforms_mul_arbiter

Round-robin arbiter that shares one signed×unsigned multiplier (30-bit signed × 29-bit unsigned → 58-bit product) among NUM_REQ waveform voice channels. It sits between the per-voice phase/amplitude scaling logic and the mixer. Each voice issues a multiply request through a valid/ready handshake. Results return in grant order on a single valid/ready output, tagged with the requester index.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- A_WIDTH, 30, operand A width, signed two's complement
- B_WIDTH, 29, operand B width, unsigned
- P_WIDTH, 58, product width, signed
- ID_WIDTH, 2, requester tag width, equal to $clog2(NUM_REQ)

Ports:
- ap_clk  in  1  single clock; all logic on the rising edge
- ap_rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- req_a  in  NUM_REQ*A_WIDTH  operand A, requester i in bits [i*A_WIDTH +: A_WIDTH]
- req_b  in  NUM_REQ*B_WIDTH  operand B, requester i in bits [i*B_WIDTH +: B_WIDTH]
- res_valid  out  1  result valid
- res_ready  in  1  downstream accept
- res_data  out  P_WIDTH  product
- res_id  out  ID_WIDTH  index of the requester that produced res_data
- busy  out  1  high while any pipeline stage holds a result

## Operation
Arithmetic:
- product = $signed(a) * $signed({1'b0, b}).
- res_data is the low P_WIDTH bits; higher bits are truncated and wrap, with no saturation.

Arbitration:
- Round-robin pointer rr_ptr, reset to 0.
- Search order is rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
- The first requester with req_valid high is the candidate.
- The grant fires (req_ready[cand]=1) only when the issue stage can accept.
- On a fire, rr_ptr becomes (cand+1) mod NUM_REQ.
- With no fire, rr_ptr holds.
- req_ready is combinational from req_valid, rr_ptr and the pipeline state. It never depends on req_a or req_b.

Output FSM (one per output register):
- S_EMPTY: res_valid=0.
  - Fire → S_FULL.
- S_FULL: res_valid=1.
  - res_ready=1 with a same-cycle fire → S_FULL, new result loaded.
  - res_ready=1 with no fire → S_EMPTY.
  - res_ready=0 → S_FULL; res_data and res_id hold stable.

Issue stage accepts when the output register is S_EMPTY, or when it is S_FULL and res_ready=1. Full throughput is one product per cycle.

busy = res_valid, or res_valid OR'd with the stage-1 valid when WAVERFORMS_MUL_ARB_PIPE_EN is defined.

## Timing
- Reset values: req_ready=0, res_valid=0, res_data=0, res_id=0, busy=0, rr_ptr=0, FSM=S_EMPTY.
- Latency, default build: fire in cycle N → res_valid=1 with the result in cycle N+1.
- Latency, pipelined build: N+2.
- Backpressure: while res_valid=1 and res_ready=0, all req_ready are 0 and no operand is sampled.
- Simultaneous valid from all requesters with res_ready=1: grants cycle 0,1,2,3,0,… (from reset), one per cycle.
- A requester dropping req_valid before it fires is legal; the arbiter never latches a request that did not fire.
- Reset mid-operation: in-flight results are discarded, with no res_valid pulse after ap_rst deasserts until a new fire.
- No combinational path from res_ready to res_data.
- The path from res_ready to req_ready is combinational.

## Configuration
- WAVERFORMS_MUL_ARB_PIPE_EN undefined:
  - operand mux → multiply → output register; latency 1.
- WAVERFORMS_MUL_ARB_PIPE_EN defined:
  - Adds a register after the operand mux (stage-1 valid, a, b, id); the multiply is computed from the stage-1 registers; latency 2.
  - Stage 1 advances when the output register can accept.
  - Fire requires stage 1 empty or advancing.
  - Throughput stays 1/cycle.
  - Ordering and round-robin are unchanged.

## Test plan
- Single request: req_valid=4'b0010, a=-3, b=5, res_ready=1 → req_ready=4'b0010 for one cycle; res_valid at N+1 (N+2 with PIPE_EN), res_data=-15, res_id=1.
- Extremes: a=-2^29, b=2^29-1 → res_data = low 58 bits of -(2^58-2^29); a=2^29-1, b=2^29-1 → low 58 bits of (2^29-1)^2, checked against a 60-bit reference model.
- Fairness: all four req_valid held high from reset, res_ready=1 → grant sequence 0,1,2,3,0,1; res_id stream matches; no requester starved for more than 3 cycles.
- Backpressure: res_ready=0 for 5 cycles while res_valid=1 → req_ready=0, res_data/res_id stable; res_ready=1 → resumes with no loss or duplication.
- Reset mid-stream: assert ap_rst for 1 cycle with results in flight → all outputs 0 the next cycle, rr_ptr=0, no stale res_valid afterwards.
- Random stimulus, 10k cycles, random req_valid and res_ready → scoreboard of (id, product) in fire order matches the output exactly, in both macro builds.

Source files
------------

// File: rtl/waverforms_mul_arbiter.sv
// ---------------------------------------------------------------------------
// waverforms_mul_arbiter
//
// Shares one signed x unsigned multiplier among NUM_REQ waveform voice
// channels. A round-robin arbiter picks one requesting voice per cycle. Its
// operands are multiplied and the product is returned on a single
// valid/ready result port. The result is tagged with the index of the
// requester that issued it, and results come back in grant order.
//
// Optional build macro:
//   WAVERFORMS_MUL_ARB_PIPE_EN - inserts an operand register between the
//   arbiter mux and the multiplier. Latency grows from 1 to 2 cycles.
//   Throughput stays one product per cycle.
//
// Ports:
//   ap_clk     - clock, everything on the rising edge
//   ap_rst     - synchronous active-high reset
//   req_valid  - per-requester request valid           [NUM_REQ]
//   req_ready  - per-requester accept, one-hot or zero [NUM_REQ]
//   req_a      - packed signed operand A per requester [NUM_REQ*A_WIDTH]
//   req_b      - packed unsigned operand B             [NUM_REQ*B_WIDTH]
//   res_valid  - result valid (registered)
//   res_ready  - downstream accept
//   res_data   - low P_WIDTH bits of the product (registered)
//   res_id     - requester index of res_data (registered)
//   busy       - any pipeline stage holds a result
// ---------------------------------------------------------------------------
module waverforms_mul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 30,
  parameter int B_WIDTH  = 29,
  parameter int P_WIDTH  = 58,
  parameter int ID_WIDTH = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [P_WIDTH-1:0]           res_data,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic                         busy
);

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } out_state_t;

  // Round-robin search from ptr. Returns {found, index}. The request vector is
  // rotated so that bit 0 is the requester at ptr. The lowest set bit of the
  // rotated vector is then the first requester in search order.
  function automatic logic [ID_WIDTH:0] find_cand(
    input logic [NUM_REQ-1:0]  valid,
    input logic [ID_WIDTH-1:0] ptr
  );
    logic [2*NUM_REQ-1:0] dbl;
    logic [ID_WIDTH:0]    result;
    int                   pos;
    dbl    = {valid, valid} >> ptr;
    result = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        pos = int'(ptr) + k;
        if (pos >= NUM_REQ) begin
          pos = pos - NUM_REQ;
        end else begin
          pos = pos;
        end
        result = {1'b1, ID_WIDTH'(pos)};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Signed A times unsigned B, truncated to P_WIDTH bits. Both operands are
  // extended to P_WIDTH bits: A with its sign bit and B with zeros. The low
  // P_WIDTH bits of that product then equal the true product modulo
  // 2^P_WIDTH, which gives the required wrap without saturation.
  function automatic logic [P_WIDTH-1:0] mul_trunc(
    input logic [A_WIDTH-1:0] a,
    input logic [B_WIDTH-1:0] b
  );
    logic [P_WIDTH-1:0] a_ext;
    logic [P_WIDTH-1:0] b_ext;
    a_ext = {{(P_WIDTH - A_WIDTH){a[A_WIDTH-1]}}, a};
    b_ext = {{(P_WIDTH - B_WIDTH){1'b0}}, b};
    return a_ext * b_ext;
  endfunction

  logic [ID_WIDTH-1:0] rr_ptr_r;
  logic [ID_WIDTH:0]   search_s;
  logic                found_s;
  logic [ID_WIDTH-1:0] cand_s;
  logic                out_accept_s;
  logic                fire_s;
  logic                load_s;
  logic [A_WIDTH-1:0]  sel_a_s;
  logic [B_WIDTH-1:0]  sel_b_s;
  logic [A_WIDTH-1:0]  mul_a_s;
  logic [B_WIDTH-1:0]  mul_b_s;
  logic [ID_WIDTH-1:0] load_id_s;
  logic [P_WIDTH-1:0]  prod_s;
  out_state_t          state_r;
  out_state_t          state_next_s;
  logic [P_WIDTH-1:0]  res_data_r;
  logic [ID_WIDTH-1:0] res_id_r;

  assign search_s = find_cand(req_valid, rr_ptr_r);
  assign found_s  = search_s[ID_WIDTH];
  assign cand_s   = search_s[ID_WIDTH-1:0];

  // The output register can take a new result when it is empty or is being
  // drained this cycle. Reset blocks any grant. This keeps req_ready at zero
  // while ap_rst is high, so nothing fires into a stage that is being cleared.
  assign out_accept_s = (state_r == S_EMPTY) | res_ready;
  assign fire_s       = found_s & out_accept_s & ~ap_rst;

  // Grant decode: one-hot on the candidate, only when the grant really fires.
  always_comb begin
    req_ready = '0;
    if (fire_s) begin
      req_ready = {{(NUM_REQ - 1){1'b0}}, 1'b1} << cand_s;
    end else begin
      req_ready = '0;
    end
  end

  // Operand mux: select the candidate's A and B fields.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand_s == ID_WIDTH'(i)) begin
        sel_a_s = req_a[i*A_WIDTH +: A_WIDTH];
        sel_b_s = req_b[i*B_WIDTH +: B_WIDTH];
      end else begin
        sel_a_s = sel_a_s;
        sel_b_s = sel_b_s;
      end
    end
  end

  // Round-robin pointer: move just past the requester that fired.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr_r <= '0;
    end else if (fire_s) begin
      rr_ptr_r <= (cand_s == LAST_ID) ? '0 : cand_s + ID_WIDTH'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

`ifdef WAVERFORMS_MUL_ARB_PIPE_EN
  logic                s1_valid_r;
  logic [A_WIDTH-1:0]  s1_a_r;
  logic [B_WIDTH-1:0]  s1_b_r;
  logic [ID_WIDTH-1:0] s1_id_r;

  // Stage-1 operand register. It advances in lockstep with the output
  // register. Operands are captured only on a real fire, so a request that
  // is withdrawn before being granted is never latched.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_id_r    <= '0;
    end else if (out_accept_s) begin
      s1_valid_r <= fire_s;
      if (fire_s) begin
        s1_a_r  <= sel_a_s;
        s1_b_r  <= sel_b_s;
        s1_id_r <= cand_s;
      end else begin
        s1_a_r  <= s1_a_r;
        s1_b_r  <= s1_b_r;
        s1_id_r <= s1_id_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_a_r     <= s1_a_r;
      s1_b_r     <= s1_b_r;
      s1_id_r    <= s1_id_r;
    end
  end

  assign load_s    = s1_valid_r & out_accept_s;
  assign mul_a_s   = s1_a_r;
  assign mul_b_s   = s1_b_r;
  assign load_id_s = s1_id_r;
  assign busy      = res_valid | s1_valid_r;
`else
  assign load_s    = fire_s;
  assign mul_a_s   = sel_a_s;
  assign mul_b_s   = sel_b_s;
  assign load_id_s = cand_s;
  assign busy      = res_valid;
`endif

  assign prod_s = mul_trunc(mul_a_s, mul_b_s);

  // Output FSM state register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r <= S_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Output FSM next state: fill on load, empty when drained without a refill.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_EMPTY: begin
        if (load_s) begin
          state_next_s = S_FULL;
        end else begin
          state_next_s = S_EMPTY;
        end
      end
      S_FULL: begin
        if (load_s) begin
          state_next_s = S_FULL;
        end else if (res_ready) begin
          state_next_s = S_EMPTY;
        end else begin
          state_next_s = S_FULL;
        end
      end
      default: begin
        state_next_s = S_EMPTY;
      end
    endcase
  end

  // Output data register. It is written only on load, so it holds steady
  // under backpressure. There is no path from res_ready to res_data
  // other than through this register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      res_data_r <= '0;
      res_id_r   <= '0;
    end else if (load_s) begin
      res_data_r <= prod_s;
      res_id_r   <= load_id_s;
    end else begin
      res_data_r <= res_data_r;
      res_id_r   <= res_id_r;
    end
  end

  assign res_valid = (state_r == S_FULL);
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;

endmodule
